// File: rtl/csr_stage_if.sv
// EXE-stage <-> CSR unit bundle: instruction, live counters, and the CSR unit's responses.
interface csr_stage_if;
    typedef struct packed {
        logic [2:0]  csr_cmd;
        logic [31:0] op1_data;
    } ctrltype;

    logic        csr_valid;
    logic [31:0] csr_reg_pc;
    logic [31:0] csr_inst;
    logic [63:0] csr_inst_id;
    ctrltype     csr_ctrl;
    logic [63:0] reg_cycle;
    logic [63:0] reg_time;
    logic [63:0] reg_mtime;
    logic [63:0] reg_mtimecmp;
    logic [31:0] csr_mem_csr_rdata;
    logic        csr_stall_flg;
    logic        csr_trap_flg;
    logic [31:0] csr_trap_vector;

    modport master (
        output csr_valid, csr_reg_pc, csr_inst, csr_inst_id, csr_ctrl,
        output reg_cycle, reg_time, reg_mtime, reg_mtimecmp,
        input  csr_mem_csr_rdata, csr_stall_flg, csr_trap_flg, csr_trap_vector
    );

    modport slave (
        input  csr_valid, csr_reg_pc, csr_inst, csr_inst_id, csr_ctrl,
        input  reg_cycle, reg_time, reg_mtime, reg_mtimecmp,
        output csr_mem_csr_rdata, csr_stall_flg, csr_trap_flg, csr_trap_vector
    );
endinterface

// File: rtl/csr_stage.sv
// Machine-mode CSR file with ECALL/MRET/timer-interrupt trap sequencing for the EXE stage.
// Define CSR_TIMER_INTERRUPT_EN to enable MTIP and timer interrupts.
module csr_stage #(
    parameter int unsigned FMAX_MHz = 27
) (
    input logic        clk,
    input logic        reset,
    csr_stage_if.slave bus
);
    localparam logic [2:0] CSR_X     = 3'd0;
    localparam logic [2:0] CSR_W     = 3'd1;
    localparam logic [2:0] CSR_S     = 3'd2;
    localparam logic [2:0] CSR_C     = 3'd3;
    localparam logic [2:0] CSR_ECALL = 3'd4;
    localparam logic [2:0] CSR_MRET  = 3'd5;

    typedef enum logic [0:0] {StIdle, StTrap} state_e;

    state_e      state_q;
    logic        mie_q, mpie_q, mtie_q;
    logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [63:0] last_id_q;
    logic        id_valid_q;
    logic        trap_flg_q;
    logic [31:0] trap_vec_q;

    logic [11:0] csr_addr;
    logic [2:0]  cmd;
    logic [31:0] op1;
    logic        mtip;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic        new_inst, irq, trap_req, commit, wr_en;

    assign csr_addr = bus.csr_inst[31:20];
    assign cmd      = bus.csr_ctrl.csr_cmd;
    assign op1      = bus.csr_ctrl.op1_data;

`ifdef CSR_TIMER_INTERRUPT_EN
    assign mtip = bus.reg_mtime >= bus.reg_mtimecmp;
    logic unused_inputs;
    assign unused_inputs = ^{bus.csr_inst[19:0], bus.csr_reg_pc[1:0]};
`else
    assign mtip = 1'b0;
    logic unused_inputs;
    assign unused_inputs = ^{bus.csr_inst[19:0], bus.csr_reg_pc[1:0],
                             bus.reg_mtime, bus.reg_mtimecmp};
`endif

    always_comb begin
        rdata = 32'h0;
        case (csr_addr)
            12'h300: rdata = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
            12'h301: rdata = 32'h4000_0100;
            12'h304: rdata = {24'h0, mtie_q, 7'h00};
            12'h305: rdata = mtvec_q;
            12'h340: rdata = mscratch_q;
            12'h341: rdata = mepc_q;
            12'h342: rdata = mcause_q;
            12'h344: rdata = {24'h0, mtip, 7'h00};
            12'hC00: rdata = bus.reg_cycle[31:0];
            12'hC80: rdata = bus.reg_cycle[63:32];
            12'hC01: rdata = bus.reg_time[31:0];
            12'hC81: rdata = bus.reg_time[63:32];
            12'hFC0: rdata = 32'(FMAX_MHz);
            default: rdata = 32'h0;
        endcase
    end

    always_comb begin
        wdata = rdata;
        case (cmd)
            CSR_W:   wdata = op1;
            CSR_S:   wdata = rdata | op1;
            CSR_C:   wdata = rdata & ~op1;
            default: wdata = rdata;
        endcase
    end

    // An id seen before (even one that trapped) is a replay and must not act again.
    assign new_inst = bus.csr_valid && (!id_valid_q || bus.csr_inst_id != last_id_q);
    assign irq      = new_inst && mie_q && mtie_q && mtip;
    assign trap_req = (state_q == StIdle) && new_inst &&
                      (irq || cmd == CSR_ECALL || cmd == CSR_MRET);
    assign commit   = new_inst && !trap_req;
    assign wr_en    = commit && (cmd == CSR_W || cmd == CSR_S || cmd == CSR_C);

    assign bus.csr_mem_csr_rdata = rdata;
    assign bus.csr_stall_flg     = trap_req;
    assign bus.csr_trap_flg      = trap_flg_q;
    assign bus.csr_trap_vector   = trap_vec_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtie_q     <= 1'b0;
            mtvec_q    <= 32'h0;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            last_id_q  <= 64'h0;
            id_valid_q <= 1'b0;
            trap_flg_q <= 1'b0;
            trap_vec_q <= 32'h0;
        end else begin
            trap_flg_q <= 1'b0;
            trap_vec_q <= 32'h0;
            case (state_q)
                StIdle: begin
                    if (trap_req) begin
                        state_q    <= StTrap;
                        trap_flg_q <= 1'b1;
                        last_id_q  <= bus.csr_inst_id;
                        id_valid_q <= 1'b1;
                        // Interrupt wins: the instruction in EXE is not executed.
                        if (irq || cmd == CSR_ECALL) begin
                            mepc_q     <= {bus.csr_reg_pc[31:2], 2'b00};
                            mcause_q   <= irq ? 32'h8000_0007 : 32'd11;
                            mpie_q     <= mie_q;
                            mie_q      <= 1'b0;
                            trap_vec_q <= {mtvec_q[31:2], 2'b00};
                        end else begin
                            mie_q      <= mpie_q;
                            mpie_q     <= 1'b1;
                            trap_vec_q <= mepc_q;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (commit) begin
                last_id_q  <= bus.csr_inst_id;
                id_valid_q <= 1'b1;
            end
            if (wr_en) begin
                case (csr_addr)
                    12'h300: begin
                        mie_q  <= wdata[3];
                        mpie_q <= wdata[7];
                    end
                    12'h304: mtie_q     <= wdata[7];
                    12'h305: mtvec_q    <= wdata;
                    12'h340: mscratch_q <= wdata;
                    12'h341: mepc_q     <= {wdata[31:2], 2'b00};
                    12'h342: mcause_q   <= wdata;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_csr_stage.sv
// Scoreboard bench for csr_stage: the driver predicts each cycle's outputs from a CSR model,
// a negedge monitor pops and compares.
module tb_csr_stage;
    localparam logic [2:0] C_X = 3'd0, C_W = 3'd1, C_S = 3'd2, C_C = 3'd3;
    localparam logic [2:0] C_ECALL = 3'd4, C_MRET = 3'd5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    csr_stage_if bus ();
    csr_stage #(.FMAX_MHz(27)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [31:0] rdata;
        logic        stall;
        logic        trap;
        logic [31:0] vec;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    // Reference state: architectural CSRs plus the pending redirect.
    bit          m_mie, m_mpie, m_mtie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    bit          m_idv;
    logic [63:0] m_last;
    bit          m_trap;
    logic [31:0] m_vec;
    longint unsigned id_ctr = 0;

    function automatic void model_reset();
        m_mie = 0; m_mpie = 0; m_mtie = 0;
        m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        m_idv = 0; m_last = 0; m_trap = 0; m_vec = 0;
    endfunction

    function automatic bit model_mtip();
`ifdef CSR_TIMER_INTERRUPT_EN
        return bus.reg_mtime >= bus.reg_mtimecmp;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return (m_mie ? 32'h8 : 0) | (m_mpie ? 32'h80 : 0);
            12'h301: return 32'h4000_0100;
            12'h304: return m_mtie ? 32'h80 : 0;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return model_mtip() ? 32'h80 : 0;
            12'hC00: return bus.reg_cycle[31:0];
            12'hC80: return bus.reg_cycle[63:32];
            12'hC01: return bus.reg_time[31:0];
            12'hC81: return bus.reg_time[63:32];
            12'hFC0: return 32'd27;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_write(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
            12'h304: m_mtie = v[7];
            12'h305: m_mtvec = v;
            12'h340: m_mscratch = v;
            12'h341: m_mepc = v & ~32'h3;
            12'h342: m_mcause = v;
            default: ;
        endcase
    endfunction

    // Apply one cycle of inputs at posedge+1, queue the expectation, advance the model.
    task automatic drive(input bit v, input logic [31:0] pc, input logic [11:0] a,
                         input logic [2:0] cmd, input logic [31:0] op1, input logic [63:0] id);
        exp_t e;
        bit nw, irq, tk;
        logic [31:0] old;
        bus.csr_valid = v;
        bus.csr_reg_pc = pc;
        bus.csr_inst = {a, 20'($urandom)};
        bus.csr_ctrl.csr_cmd = cmd;
        bus.csr_ctrl.op1_data = op1;
        bus.csr_inst_id = id;
        old = model_read(a);
        nw = v && (!m_idv || id != m_last);
        irq = nw && m_mie && m_mtie && model_mtip();
        tk = !m_trap && nw && (irq || cmd == C_ECALL || cmd == C_MRET);
        e.rdata = old;
        e.stall = tk;
        e.trap = m_trap;
        e.vec = m_trap ? m_vec : 32'h0;
        exp_q.push_back(e);
        m_trap = tk;
        m_vec = 0;
        if (nw) begin
            m_idv = 1;
            m_last = id;
        end
        if (tk) begin
            if (irq || cmd == C_ECALL) begin
                m_mepc = pc & ~32'h3;
                m_mcause = irq ? 32'h8000_0007 : 32'd11;
                m_mpie = m_mie;
                m_mie = 0;
                m_vec = m_mtvec & ~32'h3;
            end else begin
                m_mie = m_mpie;
                m_mpie = 1;
                m_vec = m_mepc;
            end
        end else if (nw) begin
            case (cmd)
                C_W: model_write(a, op1);
                C_S: model_write(a, old | op1);
                C_C: model_write(a, old & ~op1);
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [11:0] a, input logic [2:0] cmd, input logic [31:0] op1,
                         input logic [31:0] pc);
        id_ctr++;
        drive(1'b1, pc, a, cmd, op1, id_ctr);
    endtask

    task automatic idle_cycle();
        drive(1'b0, 32'h0, 12'h000, C_X, 32'h0, 64'h0);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rdata", bus.csr_mem_csr_rdata, e.rdata);
                check("stall", 32'(bus.csr_stall_flg), 32'(e.stall));
                check("trap_flg", 32'(bus.csr_trap_flg), 32'(e.trap));
                check("trap_vector", bus.csr_trap_vector, e.vec);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [11:0] addrs [16];
        logic [2:0] cmd;
        logic [63:0] id;
        addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                  12'hF14, 12'hC00, 12'hC80, 12'hC01, 12'hC81, 12'hFC0, 12'h123, 12'h7C0};
        bus.csr_valid = 0; bus.csr_reg_pc = 0; bus.csr_inst = 0; bus.csr_inst_id = 0;
        bus.csr_ctrl = '0;
        bus.reg_cycle = 64'h1111_2222_3333_4444; bus.reg_time = 64'h5555_6666_7777_8888;
        bus.reg_mtime = 0; bus.reg_mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;

        // Reset contents and read-only/counter views.
        foreach (addrs[i]) issue(addrs[i], C_X, 32'h0, 32'h0);

        // csrrw mtvec, then read back.
        issue(12'h305, C_W, 32'h8000_0100, 32'h100);
        issue(12'h305, C_X, 32'h0, 32'h104);
        issue(12'h301, C_W, 32'hFFFF_FFFF, 32'h108);
        issue(12'h301, C_X, 32'h0, 32'h10C);

        // ECALL with mtvec=0x104.
        issue(12'h305, C_W, 32'h104, 32'h110);
        issue(12'h000, C_ECALL, 32'h0, 32'h200);
        idle_cycle();
        issue(12'h341, C_X, 32'h0, 32'h104);
        issue(12'h342, C_X, 32'h0, 32'h108);

        // MRET with mepc=0x204, MPIE=1.
        issue(12'h341, C_W, 32'h204, 32'h10C);
        issue(12'h300, C_W, 32'h80, 32'h110);
        issue(12'h000, C_MRET, 32'h0, 32'h114);
        idle_cycle();
        issue(12'h300, C_X, 32'h0, 32'h204);

        // Same id held for three cycles sets MIE once.
        issue(12'h300, C_W, 32'h0, 32'h208);
        id_ctr++;
        repeat (3) drive(1'b1, 32'h20C, 12'h300, C_S, 32'h8, id_ctr);
        issue(12'h300, C_X, 32'h0, 32'h210);

        // Timer interrupt pending vs. not pending.
        issue(12'h304, C_W, 32'h80, 32'h214);
        bus.reg_mtime = 100; bus.reg_mtimecmp = 50;
        issue(12'h344, C_X, 32'h0, 32'h218);
        issue(12'h000, C_X, 32'h0, 32'h300);
        idle_cycle();
        issue(12'h342, C_X, 32'h0, 32'h104);
        issue(12'h341, C_X, 32'h0, 32'h108);
        issue(12'h300, C_S, 32'h8, 32'h10C);
        bus.reg_mtime = 40;
        issue(12'h000, C_X, 32'h0, 32'h300);
        issue(12'h344, C_X, 32'h0, 32'h304);

        // Randomised traffic; the slot after a stall is the redirect cycle, driven empty.
        id = 0;
        for (int n = 0; n < 400; n++) begin
            bus.reg_cycle = {$urandom, $urandom};
            bus.reg_time = {$urandom, $urandom};
            bus.reg_mtime = 64'($urandom_range(0, 200));
            bus.reg_mtimecmp = 64'($urandom_range(0, 200));
            if (m_trap) begin
                idle_cycle();
                continue;
            end
            case ($urandom_range(0, 19))
                0: cmd = C_ECALL;
                1: cmd = C_MRET;
                2, 3, 4: cmd = C_X;
                5, 6, 7, 8, 9, 10: cmd = C_W;
                11, 12, 13, 14: cmd = C_S;
                default: cmd = C_C;
            endcase
            if ($urandom_range(0, 9) < 7 || id == 0) begin
                id_ctr++;
                id = id_ctr;
            end
            drive($urandom_range(0, 7) != 0, $urandom, addrs[$urandom_range(0, 15)], cmd,
                  ($urandom_range(0, 3) == 0) ? 32'h88 : $urandom, id);
        end
        bus.reg_mtime = 0; bus.reg_mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
        idle_cycle();
        idle_cycle();

        // Reset asserted during the redirect cycle.
        issue(12'h305, C_W, 32'h400, 32'h500);
        issue(12'h000, C_ECALL, 32'h0, 32'h504);
        reset = 1;
        model_reset();
        idle_cycle();
        reset = 0;
        idle_cycle();
        issue(12'h305, C_X, 32'h0, 32'h0);
        issue(12'h300, C_X, 32'h0, 32'h4);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
